// File: rtl/demux_1x3_router_if.sv
// Stream bundle for the 1:3 router: one valid/ready input, three valid/ready outputs,
// plus per-channel delivery counters and illegal-select status.
interface demux_1x3_router_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [1:0]           in_sel;

  logic                 A_valid;
  logic                 A_ready;
  logic [WIDTH-1:0]     A_data;
  logic                 B_valid;
  logic                 B_ready;
  logic [WIDTH-1:0]     B_data;
  logic                 C_valid;
  logic                 C_ready;
  logic [WIDTH-1:0]     C_data;

  logic [CNT_WIDTH-1:0] count_A;
  logic [CNT_WIDTH-1:0] count_B;
  logic [CNT_WIDTH-1:0] count_C;
  logic                 err_pulse;
  logic                 err_sticky;

  // Source/sink side: drives the input stream and the sink readies.
  modport master (
    output in_valid, in_data, in_sel,
    output A_ready, B_ready, C_ready,
    input  in_ready,
    input  A_valid, A_data, B_valid, B_data, C_valid, C_data,
    input  count_A, count_B, count_C, err_pulse, err_sticky
  );

  // Router side.
  modport slave (
    input  in_valid, in_data, in_sel,
    input  A_ready, B_ready, C_ready,
    output in_ready,
    output A_valid, A_data, B_valid, B_data, C_valid, C_data,
    output count_A, count_B, count_C, err_pulse, err_sticky
  );
endinterface

// File: rtl/demux_1x3_router.sv
// Steers a valid/ready stream into one of three independently buffered channels
// by a per-word 2-bit select; illegal selects are dropped and flagged.
module demux_1x3_router #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  demux_1x3_router_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_A       = 2'b00,
    SEL_B       = 2'b01,
    SEL_C       = 2'b10,
    SEL_ILLEGAL = 2'b11
  } sel_e;

  sel_e                 w_sel;
  logic [2:0]           w_ready;
  logic [2:0]           w_drain;
  logic [2:0]           w_load;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_illegal;

  logic [2:0]           r_valid;
  logic [WIDTH-1:0]     r_data [3];
  logic [CNT_WIDTH-1:0] r_cnt  [3];
  logic                 r_err_pulse;
  logic                 r_err_sticky;

  assign w_sel   = sel_e'(bus.in_sel);
  assign w_ready = {bus.C_ready, bus.B_ready, bus.A_ready};
  assign w_drain = r_valid & w_ready;

  // in_ready looks only at the selected channel so a stalled sink cannot block others.
  always_comb begin
    w_in_ready = 1'b0;
    if (reset_n) begin
      case (w_sel)
        SEL_A:   w_in_ready = !r_valid[0] || w_ready[0];
        SEL_B:   w_in_ready = !r_valid[1] || w_ready[1];
        SEL_C:   w_in_ready = !r_valid[2] || w_ready[2];
        default: w_in_ready = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_accept  = bus.in_valid && w_in_ready;
    w_load    = '0;
    w_load[0] = w_accept && (w_sel == SEL_A);
    w_load[1] = w_accept && (w_sel == SEL_B);
    w_load[2] = w_accept && (w_sel == SEL_C);
    w_illegal = w_accept && (w_sel == SEL_ILLEGAL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid      <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_data[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        // A load takes priority so simultaneous load+drain keeps valid high.
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= bus.in_data;
        end else if (w_drain[i]) begin
          r_valid[i] <= 1'b0;
        end
        if (w_drain[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_err_pulse  <= w_illegal;
      r_err_sticky <= r_err_sticky || w_illegal;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.A_valid    = r_valid[0];
  assign bus.B_valid    = r_valid[1];
  assign bus.C_valid    = r_valid[2];
  assign bus.A_data     = r_data[0];
  assign bus.B_data     = r_data[1];
  assign bus.C_data     = r_data[2];
  assign bus.count_A    = r_cnt[0];
  assign bus.count_B    = r_cnt[1];
  assign bus.count_C    = r_cnt[2];
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_demux_1x3_router.sv
// Directed bench for demux_1x3_router with per-channel expected-word queues.
module tb_demux_1x3_router;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  bit   mon_en;
  logic exp_err;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  demux_1x3_router_if #(.WIDTH(32), .CNT_WIDTH(8)) bus ();

  demux_1x3_router #(.WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic extra_word(input string tag, input logic [31:0] obs);
    n_checks++;
    n_errors++;
    $error("FAIL %s observed=%h expected=no word", tag, obs);
  endtask

  // Drained words are compared against the queues; err_pulse is checked every cycle.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (bus.A_valid && bus.A_ready) begin
        if (qa.size() == 0) extra_word("A_extra", bus.A_data);
        else chk("A_data", bus.A_data, qa.pop_front());
      end
      if (bus.B_valid && bus.B_ready) begin
        if (qb.size() == 0) extra_word("B_extra", bus.B_data);
        else chk("B_data", bus.B_data, qb.pop_front());
      end
      if (bus.C_valid && bus.C_ready) begin
        if (qc.size() == 0) extra_word("C_extra", bus.C_data);
        else chk("C_data", bus.C_data, qc.pop_front());
      end
      chk("err_pulse", {31'd0, bus.err_pulse}, {31'd0, exp_err});
    end
    exp_err = reset_n && bus.in_valid && (bus.in_sel == 2'b11);
  end

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    qa.delete();
    qb.delete();
    qc.delete();
    @(negedge clk);
    chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] s, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        case (s)
          2'b00:   qa.push_back(d);
          2'b01:   qb.push_back(d);
          2'b10:   qc.push_back(d);
          default: ;
        endcase
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout observed=not accepted expected=accepted within 100 cycles");
    end else begin
      case (s)
        2'b00: begin chk("lat_A_valid", {31'd0, bus.A_valid}, 32'd1); chk("lat_A_data", bus.A_data, d); end
        2'b01: begin chk("lat_B_valid", {31'd0, bus.B_valid}, 32'd1); chk("lat_B_data", bus.B_data, d); end
        2'b10: begin chk("lat_C_valid", {31'd0, bus.C_valid}, 32'd1); chk("lat_C_data", bus.C_data, d); end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    exp_err  = 1'b0;
    reset_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = 2'b00;
    bus.A_ready  = 1'b1;
    bus.B_ready  = 1'b1;
    bus.C_ready  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    chk("rst_A_valid", {31'd0, bus.A_valid}, 32'd0);
    chk("rst_B_valid", {31'd0, bus.B_valid}, 32'd0);
    chk("rst_C_valid", {31'd0, bus.C_valid}, 32'd0);
    chk("rst_A_data", bus.A_data, 32'd0);
    chk("rst_count_A", {24'd0, bus.count_A}, 32'd0);
    chk("rst_err_sticky", {31'd0, bus.err_sticky}, 32'd0);

    // 1. basic routing
    send(32'h11, 2'b00, w);
    send(32'h22, 2'b01, w);
    send(32'h33, 2'b10, w);
    idle(2);
    chk("t1_count_A", {24'd0, bus.count_A}, 32'd1);
    chk("t1_count_B", {24'd0, bus.count_B}, 32'd1);
    chk("t1_count_C", {24'd0, bus.count_C}, 32'd1);
    chk("t1_err_sticky", {31'd0, bus.err_sticky}, 32'd0);

    // 2. backpressure isolation
    do_reset();
    bus.A_ready = 1'b0;
    send(32'hAA, 2'b00, w);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAB;
    bus.in_sel   = 2'b00;
    @(negedge clk);
    chk("t2_stall_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_parked_data", bus.A_data, 32'hAA);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_stall_ready2", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("t2_still_parked", {31'd0, bus.A_valid}, 32'd1);
    bus.A_ready = 1'b1;
    send(32'hAB, 2'b00, w);
    chk("t2_release_wait", w, 32'd0);
    send(32'hBB, 2'b01, w);
    idle(2);
    chk("t2_count_A", {24'd0, bus.count_A}, 32'd2);
    chk("t2_count_B", {24'd0, bus.count_B}, 32'd1);

    // 3. full-rate streaming on B
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(i, 2'b01, w);
      chk("t3_no_stall", w, 32'd0);
    end
    idle(2);
    chk("t3_count_B", {24'd0, bus.count_B}, 32'd8);

    // 4. illegal select, including a back-to-back pair
    do_reset();
    send(32'hDEAD, 2'b11, w);
    chk("t4_accept", w, 32'd0);
    chk("t4_A_valid", {31'd0, bus.A_valid}, 32'd0);
    chk("t4_B_valid", {31'd0, bus.B_valid}, 32'd0);
    chk("t4_C_valid", {31'd0, bus.C_valid}, 32'd0);
    chk("t4_sticky", {31'd0, bus.err_sticky}, 32'd1);
    send(32'h44, 2'b00, w);
    send(32'hBEEF, 2'b11, w);
    send(32'hF00D, 2'b11, w);
    send(32'h55, 2'b10, w);
    idle(3);
    chk("t4_sticky_hold", {31'd0, bus.err_sticky}, 32'd1);
    chk("t4_count_A", {24'd0, bus.count_A}, 32'd1);

    // 5. counter wrap on C
    do_reset();
    for (int i = 0; i < 257; i++) send(32'h1000 + i, 2'b10, w);
    idle(2);
    chk("t5_count_C_wrap", {24'd0, bus.count_C}, 32'd1);

    // 6. reset mid-operation
    do_reset();
    bus.A_ready = 1'b0;
    bus.B_ready = 1'b0;
    send(32'h66, 2'b00, w);
    send(32'h77, 2'b01, w);
    bus.B_ready = 1'b1;
    send(32'h78, 2'b01, w);
    send(32'hEE, 2'b11, w);
    do_reset();
    chk("t6_A_valid", {31'd0, bus.A_valid}, 32'd0);
    chk("t6_B_valid", {31'd0, bus.B_valid}, 32'd0);
    chk("t6_count_B", {24'd0, bus.count_B}, 32'd0);
    chk("t6_sticky", {31'd0, bus.err_sticky}, 32'd0);
    bus.A_ready = 1'b1;
    send(32'h99, 2'b00, w);
    idle(2);
    chk("t6_count_A", {24'd0, bus.count_A}, 32'd1);

    chk("end_qa_empty", qa.size(), 32'd0);
    chk("end_qb_empty", qb.size(), 32'd0);
    chk("end_qc_empty", qc.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
